// File: rtl/core2axi4l_pipe_pkg.sv
// Shared types for the pipelined core-to-AXI4-Lite bridge: the transaction
// tag kept in the tracking FIFO and the AXI response codes.
package core2axi4l_pipe_pkg;

    // Response codes carried on RRESP/BRESP
    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    // Kind of transaction waiting for its response
    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_type_t;

    // Anything other than OKAY is reported to the core as an error
    function automatic logic resp_is_err(input resp_t resp);
        return (resp != OKAY);
    endfunction

endpackage

// File: rtl/core2axi4l_txn_fifo.sv
// In-order tracking FIFO: one entry per granted transaction, holding its
// type so responses can be steered back to the core in issue order.
module core2axi4l_txn_fifo
    import core2axi4l_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  txn_type_t i_push_type,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output txn_type_t o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    txn_type_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage, cleared on reset so the head never reads undefined
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= TXN_READ;
        end else if (w_push) begin
            r_mem[r_wptr] <= i_push_type;
        end
    end

endmodule

// File: rtl/core2axi4l_pipe.sv
// Pipelined core-memory-interface to AXI4-Lite master bridge. Up to
// MAX_OUTSTANDING transactions in flight, AW and W accepted independently,
// responses returned to the core strictly in issue order.
// Optional macro CORE2AXI4L_PIPE_RESP_REG_EN registers the core response
// outputs (+1 cycle latency); without it the response path is combinational.
module core2axi4l_pipe
    import core2axi4l_pipe_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    // core side
    input  logic                i_core_req,
    input  logic                i_core_we,
    input  logic [DATA_W/8-1:0] i_core_be,
    input  logic [ADDR_W-1:0]   i_core_addr,
    input  logic [DATA_W-1:0]   i_core_wdata,
    output logic                o_core_gnt,
    output logic                o_core_rvalid,
    output logic [DATA_W-1:0]   o_core_rdata,
    output logic                o_core_err,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]   o_axi_awaddr,
    output logic [2:0]          o_axi_awprot,
    output logic                o_axi_awvalid,
    input  logic                i_axi_awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]   o_axi_wdata,
    output logic [DATA_W/8-1:0] o_axi_wstrb,
    output logic                o_axi_wvalid,
    input  logic                i_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]          i_axi_bresp,
    input  logic                i_axi_bvalid,
    output logic                o_axi_bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]   o_axi_araddr,
    output logic [2:0]          o_axi_arprot,
    output logic                o_axi_arvalid,
    input  logic                i_axi_arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]   i_axi_rdata,
    input  logic [1:0]          i_axi_rresp,
    input  logic                i_axi_rvalid,
    output logic                o_axi_rready
);

    logic        w_full;
    logic        w_empty;
    txn_type_t   w_head;
    logic        w_issue;
    logic        w_rd_gnt;
    logic        w_wr_gnt;
    logic        w_gnt;
    logic        w_rd_pop;
    logic        w_wr_pop;
    logic        w_pop;
    logic        w_resp_err;
    logic [DATA_W-1:0] w_resp_rdata;
    logic        r_aw_done;
    logic        r_w_done;

    // Nothing issues while reset is held, so valids are low even if req is high
    assign w_issue = rst_n & i_core_req & ~w_full;

    assign o_axi_arvalid = w_issue & ~i_core_we;
    assign o_axi_awvalid = w_issue & i_core_we & ~r_aw_done;
    assign o_axi_wvalid  = w_issue & i_core_we & ~r_w_done;

    assign w_rd_gnt = o_axi_arvalid & i_axi_arready;
    assign w_wr_gnt = w_issue & i_core_we & (r_aw_done | i_axi_awready) & (r_w_done | i_axi_wready);
    assign w_gnt    = w_rd_gnt | w_wr_gnt;
    assign o_core_gnt = w_gnt;

    assign o_axi_awaddr = i_core_addr;
    assign o_axi_araddr = i_core_addr;
    assign o_axi_wdata  = i_core_wdata;
    assign o_axi_wstrb  = i_core_be;
    assign o_axi_awprot = 3'b000;
    assign o_axi_arprot = 3'b000;

    // Only the channel matching the oldest outstanding transaction is accepted
    assign o_axi_rready = ~w_empty & (w_head == TXN_READ);
    assign o_axi_bready = ~w_empty & (w_head == TXN_WRITE);

    assign w_rd_pop = i_axi_rvalid & o_axi_rready;
    assign w_wr_pop = i_axi_bvalid & o_axi_bready;
    assign w_pop    = w_rd_pop | w_wr_pop;

    assign w_resp_rdata = w_rd_pop ? i_axi_rdata : '0;
    assign w_resp_err   = (w_rd_pop & resp_is_err(i_axi_rresp)) |
                          (w_wr_pop & resp_is_err(i_axi_bresp));

    // Remember which write halves already handshook while waiting for the other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_wr_gnt) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (o_axi_awvalid && i_axi_awready) r_aw_done <= 1'b1;
            if (o_axi_wvalid && i_axi_wready)   r_w_done  <= 1'b1;
        end
    end

    core2axi4l_txn_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_txn_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_gnt),
        .i_push_type (i_core_we ? TXN_WRITE : TXN_READ),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

`ifdef CORE2AXI4L_PIPE_RESP_REG_EN
    logic              r_core_rvalid;
    logic [DATA_W-1:0] r_core_rdata;
    logic              r_core_err;

    // Register the response toward the core; the stage is always free to accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_core_err    <= 1'b0;
        end else begin
            r_core_rvalid <= w_pop;
            r_core_rdata  <= w_resp_rdata;
            r_core_err    <= w_resp_err;
        end
    end

    assign o_core_rvalid = r_core_rvalid;
    assign o_core_rdata  = r_core_rdata;
    assign o_core_err    = r_core_err;
`else
    assign o_core_rvalid = w_pop;
    assign o_core_rdata  = w_resp_rdata;
    assign o_core_err    = w_resp_err;
`endif

endmodule

// File: tb/tb_core2axi4l_pipe.sv
// Self-checking bench for core2axi4l_pipe (MAX_OUTSTANDING = 2). Honours
// CORE2AXI4L_PIPE_RESP_REG_EN by expecting core responses one cycle later.
module tb_core2axi4l_pipe;
    import core2axi4l_pipe_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
`ifdef CORE2AXI4L_PIPE_RESP_REG_EN
    localparam int RESP_LAT = 1;
`else
    localparam int RESP_LAT = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        coreReq, coreWe, coreGnt, coreRvalid, coreErr;
    logic [3:0]  coreBe;
    logic [31:0] coreAddr, coreWdata, coreRdata;
    logic [31:0] awAddr, wData, arAddr, rData;
    logic [2:0]  awProt, arProt;
    logic [3:0]  wStrb;
    logic        awValid, awReady, wValid, wReady, bValid, bReady;
    logic        arValid, arReady, rValid, rReady;
    logic [1:0]  bResp, rResp;

    int numTests  = 0;
    int numFailed = 0;

    core2axi4l_pipe #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_core_req(coreReq), .i_core_we(coreWe), .i_core_be(coreBe),
        .i_core_addr(coreAddr), .i_core_wdata(coreWdata),
        .o_core_gnt(coreGnt), .o_core_rvalid(coreRvalid),
        .o_core_rdata(coreRdata), .o_core_err(coreErr),
        .o_axi_awaddr(awAddr), .o_axi_awprot(awProt), .o_axi_awvalid(awValid), .i_axi_awready(awReady),
        .o_axi_wdata(wData), .o_axi_wstrb(wStrb), .o_axi_wvalid(wValid), .i_axi_wready(wReady),
        .i_axi_bresp(bResp), .i_axi_bvalid(bValid), .o_axi_bready(bReady),
        .o_axi_araddr(arAddr), .o_axi_arprot(arProt), .o_axi_arvalid(arValid), .i_axi_arready(arReady),
        .i_axi_rdata(rData), .i_axi_rresp(rResp), .i_axi_rvalid(rValid), .o_axi_rready(rReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic req, we; logic [31:0] addr, wdata; logic [3:0] be;
        logic awready, wready, arready, rvalid; logic [31:0] rdata; logic [1:0] rresp;
        logic bvalid; logic [1:0] bresp;
        logic gnt, awvalid, wvalid, arvalid, rready, bready, crvalid; logic [31:0] crdata; logic cerr;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        numTests++;
        if (got !== exp) begin
            numFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idleInputs();
        coreReq = 0; coreWe = 0; coreBe = 0; coreAddr = 0; coreWdata = 0;
        awReady = 0; wReady = 0; arReady = 0; rValid = 0; rData = 0; rResp = OKAY;
        bValid = 0; bResp = OKAY;
    endtask

    task automatic applyStimulus(input vec_t v);
        coreReq = v.req; coreWe = v.we; coreAddr = v.addr; coreWdata = v.wdata; coreBe = v.be;
        awReady = v.awready; wReady = v.wready; arReady = v.arready;
        rValid = v.rvalid; rData = v.rdata; rResp = v.rresp;
        bValid = v.bvalid; bResp = v.bresp;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic        expRv, prevRv, expErr, prevErr;
    logic [31:0] expRd, prevRd;
    logic [32:0] respQ [$];

    initial begin
        // Cycle-by-cycle vectors; response columns are the combinational view
        vecs[0]  = '{L,L,32'h0,32'h0,4'h0,          L,L,L,L,32'h0,OKAY,L,OKAY,          L,L,L,L,L,L,L,32'h0,L};
        vecs[1]  = '{H,L,32'h1000,32'h0,4'h0,       L,L,H,L,32'h0,OKAY,L,OKAY,          H,L,L,H,L,L,L,32'h0,L};
        vecs[2]  = '{L,L,32'h0,32'h0,4'h0,          L,L,L,H,32'hDEADBEEF,OKAY,L,OKAY,   L,L,L,L,H,L,H,32'hDEADBEEF,L};
        vecs[3]  = '{H,H,32'h2000,32'hCAFEF00D,4'hF,L,H,L,L,32'h0,OKAY,L,OKAY,          L,H,H,L,L,L,L,32'h0,L};
        vecs[4]  = '{H,H,32'h2000,32'hCAFEF00D,4'hF,L,H,L,L,32'h0,OKAY,L,OKAY,          L,H,L,L,L,L,L,32'h0,L};
        vecs[5]  = '{H,H,32'h2000,32'hCAFEF00D,4'hF,H,H,L,L,32'h0,OKAY,L,OKAY,          H,H,L,L,L,L,L,32'h0,L};
        vecs[6]  = '{H,L,32'h3000,32'h0,4'h0,       L,L,H,L,32'h0,OKAY,H,SLVERR,        H,L,L,H,L,H,H,32'h0,H};
        vecs[7]  = '{H,L,32'h3004,32'h0,4'h0,       L,L,L,L,32'h0,OKAY,L,OKAY,          L,L,L,H,H,L,L,32'h0,L};
        vecs[8]  = '{H,L,32'h3004,32'h0,4'h0,       L,L,H,L,32'h0,OKAY,L,OKAY,          H,L,L,H,H,L,L,32'h0,L};
        vecs[9]  = '{H,H,32'h4000,32'h12345678,4'h3,H,H,L,H,32'h11111111,SLVERR,L,OKAY, L,L,L,L,H,L,H,32'h11111111,H};
        vecs[10] = '{H,H,32'h4000,32'h12345678,4'h3,H,H,L,H,32'h22222222,OKAY,H,OKAY,   H,H,H,L,H,L,H,32'h22222222,L};
        vecs[11] = '{L,L,32'h0,32'h0,4'h0,          L,L,L,H,32'h33333333,OKAY,H,OKAY,   L,L,L,L,L,H,H,32'h0,L};
        vecs[12] = '{L,L,32'h0,32'h0,4'h0,          L,L,L,H,32'h44444444,OKAY,H,SLVERR, L,L,L,L,L,L,L,32'h0,L};

        idleInputs();
        rst_n = 0;
        #3;
        checkOutput("reset gnt", {31'b0, coreGnt}, 0);
        checkOutput("reset valids", {29'b0, awValid, wValid, arValid}, 0);
        checkOutput("reset readies", {30'b0, rReady, bReady}, 0);
        checkOutput("reset resp", {30'b0, coreRvalid, coreErr}, 0);
        checkOutput("reset rdata", coreRdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // Table-driven vectors
        prevRv = 0; prevRd = 0; prevErr = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            #4;
            checkOutput($sformatf("v%0d gnt", i), {31'b0, coreGnt}, {31'b0, vecs[i].gnt});
            checkOutput($sformatf("v%0d awvalid", i), {31'b0, awValid}, {31'b0, vecs[i].awvalid});
            checkOutput($sformatf("v%0d wvalid", i), {31'b0, wValid}, {31'b0, vecs[i].wvalid});
            checkOutput($sformatf("v%0d arvalid", i), {31'b0, arValid}, {31'b0, vecs[i].arvalid});
            checkOutput($sformatf("v%0d rready", i), {31'b0, rReady}, {31'b0, vecs[i].rready});
            checkOutput($sformatf("v%0d bready", i), {31'b0, bReady}, {31'b0, vecs[i].bready});
            if (RESP_LAT == 0) begin
                expRv = vecs[i].crvalid; expRd = vecs[i].crdata; expErr = vecs[i].cerr;
            end else begin
                expRv = prevRv; expRd = prevRd; expErr = prevErr;
            end
            checkOutput($sformatf("v%0d core rvalid", i), {31'b0, coreRvalid}, {31'b0, expRv});
            checkOutput($sformatf("v%0d core rdata", i), coreRdata, expRd);
            checkOutput($sformatf("v%0d core err", i), {31'b0, coreErr}, {31'b0, expErr});
            if (vecs[i].arvalid) checkOutput($sformatf("v%0d araddr", i), arAddr, vecs[i].addr);
            if (vecs[i].awvalid) checkOutput($sformatf("v%0d awaddr", i), awAddr, vecs[i].addr);
            if (vecs[i].wvalid) begin
                checkOutput($sformatf("v%0d wdata", i), wData, vecs[i].wdata);
                checkOutput($sformatf("v%0d wstrb", i), {28'b0, wStrb}, {28'b0, vecs[i].be});
            end
            prevRv = vecs[i].crvalid; prevRd = vecs[i].crdata; prevErr = vecs[i].cerr;
            nextCycle();
        end
        checkOutput("prot zero", {26'b0, awProt, arProt}, 0);

        // Single read: grant at cycle 0, slave answers at cycle 3
        for (int cyc = 0; cyc < 6; cyc++) begin
            idleInputs();
            if (cyc == 0) begin coreReq = 1; coreAddr = 32'h1000; arReady = 1; end
            if (cyc == 3) begin rValid = 1; rData = 32'hDEADBEEF; end
            #4;
            if (cyc == 0) checkOutput("single rd gnt", {31'b0, coreGnt}, 1);
            checkOutput($sformatf("single rd rvalid c%0d", cyc), {31'b0, coreRvalid}, {31'b0, (cyc == 3 + RESP_LAT)});
            if (cyc == 3 + RESP_LAT) begin
                checkOutput("single rd rdata", coreRdata, 32'hDEADBEEF);
                checkOutput("single rd err", {31'b0, coreErr}, 0);
            end
            nextCycle();
        end

        // Read A, write B, read C: C held off while full, B back-pressured until A pops
        respQ.delete();
        for (int cyc = 0; cyc < 8; cyc++) begin
            idleInputs();
            case (cyc)
                0: begin coreReq = 1; coreAddr = 32'h5000; arReady = 1; end
                1: begin coreReq = 1; coreWe = 1; coreAddr = 32'h6000; coreWdata = 32'h0BBB0BBB;
                         coreBe = 4'hF; awReady = 1; wReady = 1; end
                2, 3, 4: begin coreReq = 1; coreAddr = 32'h7000; arReady = 1; bValid = 1; end
                5: begin rValid = 1; rData = 32'hCCCC0003; end
                default: ;
            endcase
            if (cyc == 3) begin rValid = 1; rData = 32'hAAAA0001; end
            #4;
            case (cyc)
                0, 1: checkOutput($sformatf("order gnt c%0d", cyc), {31'b0, coreGnt}, 1);
                2: begin
                    checkOutput("order full arvalid", {31'b0, arValid}, 0);
                    checkOutput("order full gnt", {31'b0, coreGnt}, 0);
                    checkOutput("order early bready", {31'b0, bReady}, 0);
                end
                3: begin
                    checkOutput("order no bypass gnt", {31'b0, coreGnt}, 0);
                    checkOutput("order A rready", {31'b0, rReady}, 1);
                    checkOutput("order held bready", {31'b0, bReady}, 0);
                end
                4: begin
                    checkOutput("order C gnt", {31'b0, coreGnt}, 1);
                    checkOutput("order B bready", {31'b0, bReady}, 1);
                end
                5: checkOutput("order C rready", {31'b0, rReady}, 1);
                default: ;
            endcase
            if (coreRvalid) respQ.push_back({coreErr, coreRdata});
            nextCycle();
        end
        checkOutput("order resp count", respQ.size(), 3);
        if (respQ.size() == 3) begin
            checkOutput("order resp A", respQ[0][31:0], 32'hAAAA0001);
            checkOutput("order resp B", respQ[1][31:0], 32'h0);
            checkOutput("order resp C", respQ[2][31:0], 32'hCCCC0003);
            checkOutput("order resp errs", {29'b0, respQ[0][32], respQ[1][32], respQ[2][32]}, 0);
        end

        // Reset with two reads outstanding, then a stray R beat must be ignored
        for (int cyc = 0; cyc < 2; cyc++) begin
            idleInputs();
            coreReq = 1; coreAddr = 32'h8000 + 32'(cyc * 4); arReady = 1;
            #4;
            checkOutput($sformatf("pre-reset gnt c%0d", cyc), {31'b0, coreGnt}, 1);
            nextCycle();
        end
        idleInputs();
        rValid = 1; rData = 32'h5A5A5A5A;
        #4;
        rst_n = 0;
        #1;
        checkOutput("mid reset valids", {29'b0, awValid, wValid, arValid}, 0);
        checkOutput("mid reset readies", {30'b0, rReady, bReady}, 0);
        checkOutput("mid reset resp", {30'b0, coreRvalid, coreErr}, 0);
        checkOutput("mid reset rdata", coreRdata, 0);
        nextCycle();
        rst_n = 1;
        #3;
        checkOutput("post reset stray rready", {31'b0, rReady}, 0);
        checkOutput("post reset stray rvalid", {31'b0, coreRvalid}, 0);
        nextCycle();
        checkOutput("post reset stray rvalid late", {31'b0, coreRvalid}, 0);
        idleInputs();
        for (int cyc = 0; cyc < 3; cyc++) begin
            coreReq = 1; coreAddr = 32'h9000; arReady = 1;
            #4;
            checkOutput($sformatf("post reset gnt c%0d", cyc), {31'b0, coreGnt}, {31'b0, (cyc < 2)});
            nextCycle();
        end
        idleInputs();

        $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
        $finish;
    end

endmodule

// File: doc/core2axi4l_pipe.md
# core2axi4l_pipe

Pipelined, parametrised core-memory-interface to AXI4-Lite master bridge, successor to the single-outstanding converter. It sits between the Ibex instruction/data port and the AXI4-Lite interconnect. It keeps up to MAX_OUTSTANDING transactions in flight, accepts AW and W independently, and returns responses to the core strictly in issue order across read and write channels. Error is flagged only on the response beat it belongs to.

## Interface
- ADDR_W, 32, address width; must match core_if and axi4l_if.
- DATA_W, 32, data width; strobe width DATA_W/8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions; must be ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- core  core_if.slave  —  req/gnt/we/be/addr/wdata/rvalid/rdata/err.
- axi  axi4l_if.master  —  AW/W/B/AR/R channels. aclk and aresetn are not used; clk and rst_n are used instead.

## Operation
- Tracking FIFO: one entry per granted transaction, holding the type (TXN_READ/TXN_WRITE). `full` is count==MAX_OUTSTANDING; `empty` is count==0.
- Read issue: arvalid = req & ~we & ~full. gnt = arvalid & arready. Push TXN_READ on gnt.
- Write issue: awvalid = req & we & ~full & ~aw_done. wvalid = req & we & ~full & ~w_done.
- gnt = req & we & ~full & (aw_done|awready) & (w_done|wready). Push TXN_WRITE on gnt.
- aw_done is set when AW handshakes without gnt and cleared on gnt. w_done behaves the same way for W.
- The core holds req/addr/we/wdata/be until gnt. full cannot assert while a request is pending, so every valid stays high until ready (AXI-compliant). No valid depends on its ready.
- Response steering:
  - rready = ~empty & head==TXN_READ.
  - bready = ~empty & head==TXN_WRITE.
  - A response on the other channel is back-pressured until it reaches the head.
- Pop the head on (rvalid&rready) or (bvalid&bready).
- Core response:
  - rvalid = pop.
  - rdata = axi.rdata on a read pop, otherwise 0.
  - err = (read pop & rresp≠OKAY) | (write pop & bresp≠OKAY).
- The core never back-pressures responses.
- Addresses go to awaddr/araddr unchanged. wstrb = be. awprot = arprot = 0.
- Simultaneous push and pop: both take effect and count is unchanged. gnt is still blocked when full; there is no same-cycle dequeue bypass.
- FIFO empty: rready = bready = 0, so stray slave responses are ignored.
- Reset mid-transaction: FIFO flushed, flags cleared, all valids/readies low. In-flight AXI transactions are abandoned and the system-level reset must cover the slave.

## Timing
- Reset values:
  - gnt, rvalid, err, awvalid, wvalid, arvalid, rready, bready: 0.
  - rdata: 0.
- gnt is combinational in the same cycle as the accepting ready (0-cycle grant when ready is high).
- Response without macro: core.rvalid in the same cycle as the AXI handshake.
- Response with macro: core.rvalid one cycle later.
- Throughput: one grant per cycle while not full. Back-to-back reads with arready=1 and rvalid one cycle later sustain 1 transaction/cycle for MAX_OUTSTANDING≥2.

## Configuration
- CORE2AXI4L_PIPE_RESP_REG_EN defined:
  - core.rvalid/rdata/err are registered (reset 0), adding +1 cycle response latency.
  - rready/bready are unchanged (the register is always free).
- Undefined: the response path is combinational from axi R/B.

## Structure
- axi4l_pkg gains txn_type_t enum {TXN_READ, TXN_WRITE}. It already holds the resp_t OKAY/EXOKAY/SLVERR/DECERR constants.
- One sub-module, core2axi4l_txn_fifo: a synchronous FIFO, DEPTH = MAX_OUTSTANDING, element txn_type_t, with push/pop/full/empty/head outputs.
- Everything else is flat in core2axi4l_pipe.

## Test plan
- Single read 0x1000, arready=1, rvalid 3 cycles later with rdata 0xDEADBEEF/OKAY -> gnt cycle 0, core.rvalid cycle 3 with 0xDEADBEEF and err=0.
- Write 0x2000 with wready=1 and awready delayed 2 cycles -> W accepted cycle 0, AW cycle 2, gnt cycle 2, wvalid low in cycles 1–2, exactly one W beat.
- Read A, write B, read C, MAX_OUTSTANDING=2, all readies 1 -> C gnt held off until A responds.
- In the same run, bvalid(B) arrives before rvalid(A) -> bready=0 until A pops; core sees A, B, C in order.
- Read with rresp=SLVERR, then write with bresp=OKAY -> err=1 only on the read response, 0 on the write.
- rst_n pulsed low with 2 transactions outstanding -> all outputs 0 next edge, FIFO empty. A later rvalid from the slave is ignored (rready=0).
- With CORE2AXI4L_PIPE_RESP_REG_EN, repeat the first case -> core.rvalid at cycle 4.
